// File: rtl/snake_cmd_scheduler_if.sv
// Handshake bundle between the key decoder / game engine and the snake command scheduler.
interface snake_cmd_scheduler_if #(
    parameter int FIFO_AW = 2
);
    logic               cmd_valid;
    logic [3:0]         cmd;
    logic               tick;
    logic               collision;
    logic               step;
    logic [1:0]         dir;
    logic               restart;
    logic [1:0]         state;
    logic [FIFO_AW:0]   fifo_count;
    logic               overflow;

    modport master (
        output cmd_valid, cmd, tick, collision,
        input  step, dir, restart, state, fifo_count, overflow
    );

    modport slave (
        input  cmd_valid, cmd, tick, collision,
        output step, dir, restart, state, fifo_count, overflow
    );
endinterface

// File: rtl/snake_cmd_scheduler.sv
// Queues direction keys, releases at most one per game tick, and runs the
// IDLE/RUN/PAUSED/OVER control FSM that drives the engine step/restart strobes.
module snake_cmd_scheduler #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         FIFO_AW    = 2,
    parameter logic [1:0] INIT_DIR   = 2'd3
) (
    input  logic                 clock,
    input  logic                 reset,
    snake_cmd_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, OVER = 2'd3} state_t;

    state_t             st;
    logic [1:0]         dir_q;
    logic               step_q, restart_q, ovf_q;
    logic [1:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_ptr, wr_ptr, tail_ptr;
    logic [FIFO_AW:0]   cnt;

    logic       is_dir, is_start, is_pause, is_stop;
    logic       q_open, q_empty, q_full, dup, legal;
    logic       do_push, do_ovf, do_tick, do_pop, do_restart, flush;
    logic [3:0] cmd_m1;
    logic [1:0] new_dir, head, tail;

    assign is_dir   = bus.cmd_valid && (bus.cmd >= 4'd1) && (bus.cmd <= 4'd4);
    assign is_start = bus.cmd_valid && (bus.cmd == 4'd5);
    assign is_pause = bus.cmd_valid && (bus.cmd == 4'd6);
    assign is_stop  = bus.cmd_valid && (bus.cmd == 4'd7);
    assign cmd_m1   = bus.cmd - 4'd1;
    assign new_dir  = cmd_m1[1:0];

    assign tail_ptr = wr_ptr - FIFO_AW'(1);
    assign head     = mem[rd_ptr];
    assign tail     = mem[tail_ptr];
    assign q_empty  = (cnt == '0);
    assign q_full   = (cnt == (FIFO_AW+1)'(FIFO_DEPTH));
    assign q_open   = (st == RUN) || (st == PAUSED);

    // Dedupe against the tail is checked before fullness, so a repeated key never flags overflow.
    assign dup      = !q_empty && (tail == new_dir);
    assign do_push  = is_dir && q_open && !dup && !q_full;
    assign do_ovf   = is_dir && q_open && !dup && q_full;

    assign do_tick    = bus.tick && (st == RUN) && !bus.collision && !is_stop;
    assign do_pop     = do_tick && !q_empty;
    assign legal      = (head != dir_q) && (head != (dir_q ^ 2'd1));
    assign do_restart = is_start && ((st == IDLE) || (st == OVER));
    assign flush      = is_stop || do_restart;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            dir_q     <= INIT_DIR;
            step_q    <= 1'b0;
            restart_q <= 1'b0;
            ovf_q     <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            step_q    <= do_tick;
            restart_q <= do_restart;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
                dir_q  <= INIT_DIR;
                ovf_q  <= 1'b0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= new_dir;
                    wr_ptr      <= wr_ptr + FIFO_AW'(1);
                end
                // Popped head is consumed even when it is a repeat or a reversal.
                if (do_pop) begin
                    rd_ptr <= rd_ptr + FIFO_AW'(1);
                    if (legal) dir_q <= head;
                end
                if (do_ovf) ovf_q <= 1'b1;
                cnt <= cnt + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
            end

            if (is_stop) begin
                st <= IDLE;
            end else begin
                unique case (st)
                    IDLE:    if (is_start) st <= RUN;
                    RUN:     if (bus.collision) st <= OVER;
                             else if (is_pause) st <= PAUSED;
                    PAUSED:  if (is_pause || is_start) st <= RUN;
                    OVER:    if (is_start) st <= RUN;
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign bus.step       = step_q;
    assign bus.restart    = restart_q;
    assign bus.dir        = dir_q;
    assign bus.state      = st;
    assign bus.fifo_count = cnt;
    assign bus.overflow   = ovf_q;
endmodule
